// File: rtl/cmd_frame_tx_pkg.sv
// Shared types and constants for the command frame transmitter.
package cmd_frame_tx_pkg;

  // Encodings of the frame FSM states.
  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_SYNC_ENC    = 3'd1;
  localparam logic [2:0] ST_PAYLOAD_ENC = 3'd2;
  localparam logic [2:0] ST_CHECK_ENC   = 3'd3;
  localparam logic [2:0] ST_FIN_ENC     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_SYNC    = ST_SYNC_ENC,
    ST_PAYLOAD = ST_PAYLOAD_ENC,
    ST_CHECK   = ST_CHECK_ENC,
    ST_FIN     = ST_FIN_ENC
  } state_t;

  // Sync byte, four payload bytes and one checksum byte.
  localparam int         FRAME_LEN     = 6;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hFE;
  localparam logic [7:0] DEF_CHK_INIT  = 8'h00;

endpackage

// File: rtl/cmd_frame_tx_if.sv
// Byte-wide valid/ready stream between the framer and the link PHY.
interface cmd_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cmd_frame_tx_edge_detect_rise.sv
// Registered 1-bit rising-edge detector shared by the command consumers.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q_reg;

  // Delay the input by one clock. Clearing it in reset makes a level that is already high count as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q_reg <= 1'b0;
    else        d_q_reg <= d;
  end

  assign rise = d & ~d_q_reg;

endmodule

// File: rtl/cmd_frame_tx.sv
// Captures a 32-bit command result and sends it as the frame
// SYNC, B3, B2, B1, B0, XOR checksum on a byte-wide valid/ready stream.
module cmd_frame_tx
  import cmd_frame_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter logic [7:0] CHK_INIT  = DEF_CHK_INIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [31:0]           cmd_word,
  cmd_frame_tx_if.master        tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  state_t      state_reg, state_next;
  logic [31:0] cap_reg, cap_next;
  logic [7:0]  chk_reg, chk_next;
  logic [1:0]  idx_reg, idx_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_valid_reg, tx_valid_next;
  logic        busy_reg, busy_next;
  logic        frame_done_reg, frame_done_next;
  logic        overrun_reg, overrun_next;
  logic        start_evt;
  logic        xfer;
  logic [7:0]  payload_byte [4];

  edge_detect_rise u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmd_valid),
    .rise  (start_evt)
  );

  // payload_byte[0] is the most significant byte and is sent first.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign payload_byte[gi] = cap_reg[31-8*gi -: 8];
    end
  endgenerate

  assign xfer = tx_valid_reg & tx.tx_ready;

  // State and output register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cap_reg        <= '0;
      chk_reg        <= '0;
      idx_reg        <= '0;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cap_reg        <= cap_next;
      chk_reg        <= chk_next;
      idx_reg        <= idx_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Next-state logic. Bytes advance only on a completed handshake, so a stalled byte stays on the bus.
  always_comb begin
    state_next      = state_reg;
    cap_next        = cap_reg;
    chk_next        = chk_reg;
    idx_next        = idx_reg;
    tx_data_next    = tx_data_reg;
    tx_valid_next   = tx_valid_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    overrun_next    = overrun_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start_evt) begin
          cap_next      = cmd_word;
          chk_next      = CHK_INIT;
          idx_next      = 2'd0;
          busy_next     = 1'b1;
          tx_data_next  = SYNC_BYTE;
          tx_valid_next = 1'b1;
          state_next    = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (xfer) begin
          tx_data_next = payload_byte[0];
          idx_next     = 2'd0;
          state_next   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          chk_next = chk_reg ^ tx_data_reg;
          if (idx_reg != 2'd3) begin
            idx_next     = idx_reg + 2'd1;
            tx_data_next = payload_byte[idx_reg + 2'd1];
          end else begin
            tx_data_next = chk_reg ^ tx_data_reg;
            state_next   = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          tx_valid_next   = 1'b0;
          busy_next       = 1'b0;
          frame_done_next = 1'b1;
          state_next      = ST_FIN;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A command edge that cannot be served is dropped and flagged. A new event takes priority over a clear.
    if (start_evt && (state_reg != ST_IDLE)) overrun_next = 1'b1;
    else if (clr_overrun)                    overrun_next = 1'b0;
  end

  assign tx.tx_data  = tx_data_reg;
  assign tx.tx_valid = tx_valid_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;
  assign overrun     = overrun_reg;

endmodule
